// File: rtl/lamp_sqrt_issue_ctrl.sv
// Initiator-side controller for the bfloat16 sqrt unit: accepts one packed operand,
// classifies it, drives the unit until it answers (or times out), and returns the result.
module lamp_sqrt_issue_ctrl #(
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [15:0]      req_op_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             doSqrt_o,
  output logic             signum_op_o,
  output logic [7:0]       extExp_op_o,
  output logic [7:0]       extMant_op_o,
  output logic             isInf_op_o,
  output logic             isZero_op_o,
  output logic             isSNAN_op_o,
  output logic             isQNAN_op_o,
  input  logic             s_res_i,
  input  logic [7:0]       e_res_i,
  input  logic [6:0]       f_res_i,
  input  logic             valid_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [15:0]      rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] QNAN_RSP = 16'h7FC0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_q;
  logic             accept, cnt_last;

  // Operand classification of the incoming request (denormals flush to zero)
  logic [7:0] op_e;
  logic [6:0] op_f;
  logic       c_zero, c_inf, c_qnan, c_snan;
  logic [7:0] c_mant;

  assign op_e     = req_op_i[14:7];
  assign op_f     = req_op_i[6:0];
  assign c_zero   = (op_e == 8'h00);
  assign c_inf    = (op_e == 8'hFF) && (op_f == 7'd0);
  assign c_qnan   = (op_e == 8'hFF) && op_f[6];
  assign c_snan   = (op_e == 8'hFF) && !op_f[6] && (op_f != 7'd0);
  assign c_mant   = c_zero ? 8'h00 : {1'b1, op_f};

  assign accept   = req_valid_i && (state == IDLE);
  assign cnt_last = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_o = 1'b0;
    doSqrt_o    = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nxt = ISSUE;
      end
      ISSUE: begin
        doSqrt_o  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (valid_i || cnt_last) state_nxt = RESP;
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      tag_q        <= '0;
      signum_op_o  <= 1'b0;
      extExp_op_o  <= 8'h00;
      extMant_op_o <= 8'h00;
      isInf_op_o   <= 1'b0;
      isZero_op_o  <= 1'b0;
      isSNAN_op_o  <= 1'b0;
      isQNAN_op_o  <= 1'b0;
      rsp_data_o   <= 16'h0000;
      rsp_tag_o    <= '0;
      rsp_err_o    <= 1'b0;
    end else begin
      if (accept) begin
        tag_q        <= req_tag_i;
        signum_op_o  <= req_op_i[15];
        extExp_op_o  <= op_e;
        extMant_op_o <= c_mant;
        isInf_op_o   <= c_inf;
        isZero_op_o  <= c_zero;
        isSNAN_op_o  <= c_snan;
        isQNAN_op_o  <= c_qnan;
      end else if ((state == WAIT) && (valid_i || cnt_last)) begin
        signum_op_o  <= 1'b0;
        extExp_op_o  <= 8'h00;
        extMant_op_o <= 8'h00;
        isInf_op_o   <= 1'b0;
        isZero_op_o  <= 1'b0;
        isSNAN_op_o  <= 1'b0;
        isQNAN_op_o  <= 1'b0;
      end

      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;

      // A real result beats a timeout landing in the same cycle
      if (state == WAIT) begin
        if (valid_i) begin
          rsp_data_o <= {s_res_i, e_res_i, f_res_i};
          rsp_tag_o  <= tag_q;
          rsp_err_o  <= 1'b0;
        end else if (cnt_last) begin
          rsp_data_o <= QNAN_RSP;
          rsp_tag_o  <= tag_q;
          rsp_err_o  <= 1'b1;
        end
      end else if ((state == RESP) && rsp_ready_i) begin
        rsp_data_o <= 16'h0000;
        rsp_tag_o  <= '0;
        rsp_err_o  <= 1'b0;
      end
    end
  end

endmodule
